// File: rtl/ai_col_scheduler_pkg.sv
// ai_col_scheduler_pkg: board dimensions, score limits, state encoding and visit-order tables.
package ai_col_scheduler_pkg;
    localparam int NUM_COLS = 7;
    localparam int NUM_ROWS = 6;
    localparam int CNT_W    = 3;
    localparam int COL_W    = 3;
    localparam int SCORE_W  = 16;
    localparam int FIELD_W  = NUM_COLS * NUM_ROWS;
    localparam int PILED_W  = NUM_COLS * CNT_W;
    localparam logic signed [SCORE_W-1:0] SCORE_MIN = $signed({1'b1, {(SCORE_W-1){1'b0}}});
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_ROWS);
    localparam logic [COL_W-1:0] LAST_IDX = COL_W'(NUM_COLS - 1);
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REQ, S_DONE} state_e;
    // Visit index i lives at bits [i*COL_W +: COL_W].
    localparam logic [NUM_COLS*COL_W-1:0] ORDER_LINEAR = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [NUM_COLS*COL_W-1:0] ORDER_CENTER = {3'd6, 3'd0, 3'd5, 3'd1, 3'd4, 3'd2, 3'd3};
endpackage

// File: rtl/ai_col_scheduler_col_order.sv
// m_col_order: maps a visit index to a board column.
// CENTER_FIRST_ORDER_EN selects the centre-out order instead of left-to-right.
module m_col_order
    import ai_col_scheduler_pkg::*;
(
    input  logic [COL_W-1:0] idx_i,
    output logic [COL_W-1:0] col_o
);
`ifdef CENTER_FIRST_ORDER_EN
    assign col_o = ORDER_CENTER[idx_i*COL_W +: COL_W];
`else
    assign col_o = ORDER_LINEAR[idx_i*COL_W +: COL_W];
`endif
endmodule

// File: rtl/ai_col_scheduler.sv
// ai_col_scheduler: walks all non-full columns through a shared evaluator and reports the best one.
// Visit order comes from m_col_order (CENTER_FIRST_ORDER_EN selects centre-first).
module ai_col_scheduler
    import ai_col_scheduler_pkg::*;
(
    input  logic                      w_clk,
    input  logic                      w_rst,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic [FIELD_W-1:0]        i_me_field,
    input  logic [FIELD_W-1:0]        i_op_field,
    input  logic [PILED_W-1:0]        i_piled_array,
    output logic                      o_eval_req,
    output logic [COL_W-1:0]          o_eval_col,
    output logic [FIELD_W-1:0]        o_eval_me_field,
    output logic [FIELD_W-1:0]        o_eval_op_field,
    output logic [PILED_W-1:0]        o_eval_piled,
    input  logic                      i_eval_ack,
    input  logic                      i_eval_legal,
    input  logic signed [SCORE_W-1:0] i_eval_score,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [COL_W-1:0]          o_best_col,
    output logic signed [SCORE_W-1:0] o_best_score,
    output logic                      o_no_move
);
    state_e                     state_q;
    logic [COL_W-1:0]           idx_q;
    logic [COL_W-1:0]           col;
    logic [COL_W-1:0]           run_col_q;
    logic signed [SCORE_W-1:0]  run_score_q;
    logic                       found_q;
    logic                       full;
    logic                       last;
    logic                       take;
    logic                       go_done;
    logic [COL_W-1:0]           best_col_d;
    logic signed [SCORE_W-1:0]  best_score_d;
    logic                       found_d;

    m_col_order u_order (.idx_i(idx_q), .col_o(col));

    // Fullness is judged on the snapshot so the whole search sees one board.
    assign full         = o_eval_piled[col*CNT_W +: CNT_W] >= FULL_CNT;
    assign last         = idx_q == LAST_IDX;
    assign take         = state_q == S_REQ && i_eval_ack && i_eval_legal &&
                          (!found_q || i_eval_score > run_score_q);
    assign best_col_d   = take ? col : run_col_q;
    assign best_score_d = take ? i_eval_score : run_score_q;
    assign found_d      = take | found_q;
    assign go_done      = last && ((state_q == S_CHECK && full) || (state_q == S_REQ && i_eval_ack));

    assign o_eval_req = state_q == S_REQ;
    assign o_eval_col = o_eval_req ? col : '0;
    assign o_busy     = state_q == S_CHECK || state_q == S_REQ;
    assign o_done     = state_q == S_DONE;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            o_eval_me_field <= '0;
            o_eval_op_field <= '0;
            o_eval_piled    <= '0;
            run_col_q       <= '0;
            run_score_q     <= '0;
            found_q         <= 1'b0;
            o_best_col      <= '0;
            o_best_score    <= '0;
            o_no_move       <= 1'b0;
        end else if (i_abort) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (i_start) begin
                    state_q         <= S_CHECK;
                    idx_q           <= '0;
                    o_eval_me_field <= i_me_field;
                    o_eval_op_field <= i_op_field;
                    o_eval_piled    <= i_piled_array;
                    run_col_q       <= '0;
                    run_score_q     <= SCORE_MIN;
                    found_q         <= 1'b0;
                end
                S_CHECK: if (full) begin
                    idx_q   <= idx_q + 1'b1;
                    state_q <= last ? S_DONE : S_CHECK;
                end else begin
                    state_q <= S_REQ;
                end
                S_REQ: if (i_eval_ack) begin
                    run_col_q   <= best_col_d;
                    run_score_q <= best_score_d;
                    found_q     <= found_d;
                    idx_q       <= idx_q + 1'b1;
                    state_q     <= last ? S_DONE : S_CHECK;
                end
                default: state_q <= S_IDLE;
            endcase
            // Results are published on entry to DONE so they are valid alongside o_done.
            if (go_done) begin
                o_best_col   <= best_col_d;
                o_best_score <= best_score_d;
                o_no_move    <= !found_d;
            end
        end
    end
endmodule

// File: tb/tb_ai_col_scheduler.sv
// tb_ai_col_scheduler: directed self-checking bench for ai_col_scheduler.
// Honours CENTER_FIRST_ORDER_EN when choosing expected visit order and winners.
module tb_ai_col_scheduler;
    logic               w_clk = 1'b0;
    logic               w_rst = 1'b1;
    logic               i_start = 1'b0;
    logic               i_abort = 1'b0;
    logic [41:0]        i_me_field = '0;
    logic [41:0]        i_op_field = '0;
    logic [20:0]        i_piled_array = '0;
    logic               o_eval_req;
    logic [2:0]         o_eval_col;
    logic [41:0]        o_eval_me_field;
    logic [41:0]        o_eval_op_field;
    logic [20:0]        o_eval_piled;
    logic               i_eval_ack = 1'b0;
    logic               i_eval_legal = 1'b0;
    logic signed [15:0] i_eval_score = '0;
    logic               o_busy;
    logic               o_done;
    logic [2:0]         o_best_col;
    logic signed [15:0] o_best_score;
    logic               o_no_move;

    int                 n_checks = 0;
    int                 n_fail = 0;
    logic signed [15:0] score_tab [7];
    logic               legal_tab [7];
    int                 req_cols [$];
    int                 done_cyc;
    int                 nreq;
    logic               aborted;
`ifdef CENTER_FIRST_ORDER_EN
    int ord [7]  = '{3, 2, 4, 1, 5, 0, 6};
    int ord3 [4] = '{3, 4, 1, 5};
    int best1    = 3;
    int best3    = 3;
`else
    int ord [7]  = '{0, 1, 2, 3, 4, 5, 6};
    int ord3 [4] = '{1, 3, 4, 5};
    int best1    = 1;
    int best3    = 1;
`endif

    always #5 w_clk = ~w_clk;

    ai_col_scheduler dut (
        .w_clk(w_clk), .w_rst(w_rst), .i_start(i_start), .i_abort(i_abort),
        .i_me_field(i_me_field), .i_op_field(i_op_field), .i_piled_array(i_piled_array),
        .o_eval_req(o_eval_req), .o_eval_col(o_eval_col),
        .o_eval_me_field(o_eval_me_field), .o_eval_op_field(o_eval_op_field),
        .o_eval_piled(o_eval_piled), .i_eval_ack(i_eval_ack), .i_eval_legal(i_eval_legal),
        .i_eval_score(i_eval_score), .o_busy(o_busy), .o_done(o_done),
        .o_best_col(o_best_col), .o_best_score(o_best_score), .o_no_move(o_no_move)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
        check({tag, "_done"}, 64'(o_done), 64'd0);
        check({tag, "_req"}, 64'(o_eval_req), 64'd0);
    endtask

    task automatic run(input int wait_n, input int abort_at);
        int waitc = 0;
        int acks = 0;
        logic abort_sent = 1'b0;
        logic [41:0] me_snap = i_me_field;
        logic [41:0] op_snap = i_op_field;
        logic [20:0] pl_snap = i_piled_array;
        req_cols.delete();
        done_cyc = 0;
        nreq = 0;
        aborted = 1'b0;
        @(negedge w_clk);
        i_start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge w_clk);
            i_start = 1'b0;
            i_eval_ack = 1'b0;
            if (abort_sent) begin
                i_abort = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (c == 3) i_me_field = ~i_me_field;
            if (o_done) begin
                done_cyc = c;
                break;
            end
            if (o_eval_req) begin
                if (waitc == 0) begin
                    req_cols.push_back(int'(o_eval_col));
                    nreq++;
                end else begin
                    check("col_stable", 64'(o_eval_col), 64'(req_cols[$]));
                    check("me_snapshot", 64'(o_eval_me_field), 64'(me_snap));
                    check("op_snapshot", 64'(o_eval_op_field), 64'(op_snap));
                    check("piled_snapshot", 64'(o_eval_piled), 64'(pl_snap));
                end
                if (waitc >= wait_n) begin
                    i_eval_ack = 1'b1;
                    i_eval_legal = legal_tab[o_eval_col];
                    i_eval_score = score_tab[o_eval_col];
                    acks++;
                    waitc = 0;
                    if (acks == abort_at) begin
                        i_abort = 1'b1;
                        abort_sent = 1'b1;
                    end
                end else begin
                    waitc++;
                end
            end
        end
        i_eval_ack = 1'b0;
    endtask

    task automatic check_result(input string tag, input int exp_cyc, input int exp_col,
                                input logic [15:0] exp_score, input logic exp_nm);
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
        check({tag, "_best_col"}, 64'(o_best_col), 64'(exp_col));
        check({tag, "_best_score"}, {48'd0, o_best_score}, {48'd0, exp_score});
        check({tag, "_no_move"}, 64'(o_no_move), 64'(exp_nm));
        @(negedge w_clk);
        check_idle_outs({tag, "_after"});
    endtask

    initial begin
        for (int i = 0; i < 7; i++) legal_tab[i] = 1'b1;
        #1;
        check_idle_outs("reset");
        check("reset_best_col", 64'(o_best_col), 64'd0);
        check("reset_best_score", {48'd0, o_best_score}, 64'd0);
        check("reset_no_move", 64'(o_no_move), 64'd0);
        check("reset_eval_col", 64'(o_eval_col), 64'd0);
        repeat (2) @(negedge w_clk);
        w_rst = 1'b0;

        // Empty board, zero-wait ack, ties at score 5.
        i_me_field = 42'h0123456789A;
        i_op_field = 42'h2A5A5A5A5A5;
        score_tab = '{16'sd1, 16'sd5, 16'sd3, 16'sd5, -16'sd2, 16'sd0, 16'sd4};
        run(0, 0);
        check("t1_nreq", 64'(nreq), 64'd7);
        for (int i = 0; i < 7; i++)
            check("t1_order", 64'(i < req_cols.size() ? req_cols[i] : -1), 64'(ord[i]));
        check_result("t1", 15, best1, 16'h0005, 1'b0);

        // Columns 0, 2 and 6 full; remaining scores all equal.
        i_piled_array = '0;
        i_piled_array[0 +: 3] = 3'd6;
        i_piled_array[6 +: 3] = 3'd6;
        i_piled_array[18 +: 3] = 3'd6;
        i_piled_array[3 +: 3] = 3'd5;
        score_tab = '{16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7};
        run(0, 0);
        check("t2_nreq", 64'(nreq), 64'd4);
        for (int i = 0; i < 4; i++)
            check("t2_order", 64'(i < req_cols.size() ? req_cols[i] : -1), 64'(ord3[i]));
        check_result("t2", 12, best3, 16'h0007, 1'b0);

        // Every column full (one above the row count).
        for (int c = 0; c < 7; c++) i_piled_array[c*3 +: 3] = (c == 5) ? 3'd7 : 3'd6;
        run(0, 0);
        check("t3_nreq", 64'(nreq), 64'd0);
        check_result("t3", 8, 0, 16'h8000, 1'b1);

        // Three-cycle ack latency, all negative scores, best one illegal.
        i_piled_array = '0;
        score_tab = '{-16'sd5, -16'sd3, -16'sd8, -16'sd1, -16'sd9, -16'sd4, -16'sd7};
        legal_tab[3] = 1'b0;
        run(3, 0);
        check("t4_nreq", 64'(nreq), 64'd7);
        check_result("t4", 36, 1, 16'hFFFD, 1'b0);
        legal_tab[3] = 1'b1;

        // Abort coinciding with the fourth ack.
        score_tab = '{16'sd1, 16'sd5, 16'sd3, 16'sd5, -16'sd2, 16'sd0, 16'sd4};
        run(0, 4);
        check("t5_aborted", 64'(aborted), 64'd1);
        check_idle_outs("t5_abort");
        check("t5_best_col", 64'(o_best_col), 64'd1);
        check("t5_best_score", {48'd0, o_best_score}, 64'hFFFD);
        check("t5_no_move", 64'(o_no_move), 64'd0);
        @(negedge w_clk);
        check_idle_outs("t5_abort_hold");
        run(0, 0);
        check("t5_rerun_nreq", 64'(nreq), 64'd7);
        check_result("t5_rerun", 15, best1, 16'h0005, 1'b0);

        // Asynchronous reset while a request is outstanding.
        @(negedge w_clk);
        i_start = 1'b1;
        @(negedge w_clk);
        i_start = 1'b0;
        for (int c = 0; c < 10 && !o_eval_req; c++) @(negedge w_clk);
        check("t6_req_before_rst", 64'(o_eval_req), 64'd1);
        #2 w_rst = 1'b1;
        #1;
        check_idle_outs("t6_rst");
        check("t6_best_col", 64'(o_best_col), 64'd0);
        check("t6_best_score", {48'd0, o_best_score}, 64'd0);
        check("t6_no_move", 64'(o_no_move), 64'd0);
        check("t6_eval_col", 64'(o_eval_col), 64'd0);
        check("t6_me_field", 64'(o_eval_me_field), 64'd0);
        @(negedge w_clk);
        w_rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
